// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL mode sequencer: FSM state encoding and
// fixed timing constants of the reconfiguration protocol.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_WAIT_IDLE,
    ST_WAIT_CFG,
    ST_WAIT_LOCK,
    ST_SUCCESS,
    ST_FAIL
  } seq_state_t;

  localparam int LOCK_STABLE_CYCLES = 4;
  localparam int BUSY_IGNORE_CYCLES = 2;

  // "No failed mode" is the first code past the last real mode.
  function automatic int none_mode(input int num_modes);
    return num_modes;
  endfunction

endpackage

// File: rtl/mode_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output takes a
// new value only after it has held for STABLE cycles and is below LIMIT.
module mode_debounce #(
  parameter int             W         = 1,
  parameter int             STABLE    = 4,
  parameter int             LIMIT     = 2,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam int CW = $clog2(STABLE + 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  // cnt saturates at STABLE so a held value is accepted exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      cand   <= RESET_VAL;
      cnt    <= CW'(STABLE);
      stable <= RESET_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CW'(1);
      end else if (cnt < CW'(STABLE)) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(STABLE - 1) && {1'b0, cand} < (W + 1)'(LIMIT)) begin
          stable <= cand;
        end
      end
    end
  end

endmodule

// File: rtl/pll_mode_sequencer.sv
// Runtime PLL reconfiguration sequencer: debounces the requested mode, drives
// the pll_reconfig ROM load / start pulses, waits for lock and retries on failure.
module pll_mode_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_MODES     = 2,
  parameter int MODE_W        = $clog2(NUM_MODES),
  parameter int RESET_MODE    = 0,
  parameter int STABLE_CYCLES = 16,
  parameter int BUSY_TIMEOUT  = 1000,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic [MODE_W-1:0]  mode_i,
  input  logic               force_i,
  input  logic               pll_locked_i,
  input  logic               busy_i,
  output logic               write_from_rom_o,
  output logic               reconfig_o,
  output logic               reconfig_reset_o,
  output logic [MODE_W-1:0]  rom_sel_o,
  output logic [MODE_W-1:0]  active_mode_o,
  output logic               seq_busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output seq_state_t         state_o
);

  localparam int TIMER_MAX = (BUSY_TIMEOUT > LOCK_TIMEOUT) ? BUSY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam logic [MODE_W:0]   NONE_MODE = (MODE_W + 1)'(none_mode(NUM_MODES));
  localparam logic [MODE_W-1:0] RST_MODE  = MODE_W'(RESET_MODE);
  localparam logic [TW-1:0]     CFG_CHECK = TW'(BUSY_TIMEOUT - BUSY_IGNORE_CYCLES);

  seq_state_t state, state_d;
  logic [TW-1:0]      timer, timer_d;
  logic [MODE_W-1:0]  target, target_q;
  logic [MODE_W-1:0]  rom_sel_d, active_d;
  logic [MODE_W:0]    failed_mode, failed_d;
  logic [RETRY_W-1:0] retry_d;
  logic               error_d, wfr_d, rcfg_d, rrst_d, done_d;
  logic               lock_ok;

  mode_debounce #(
    .W(MODE_W), .STABLE(STABLE_CYCLES), .LIMIT(NUM_MODES), .RESET_VAL(RST_MODE)
  ) u_mode_db (
    .clk(clk_i), .rst_n(reset_n), .din(mode_i), .stable(target)
  );

  mode_debounce #(
    .W(1), .STABLE(LOCK_STABLE_CYCLES), .LIMIT(2), .RESET_VAL(1'b0)
  ) u_lock_db (
    .clk(clk_i), .rst_n(reset_n), .din(pll_locked_i), .stable(lock_ok)
  );

  // Handshake with pll_reconfig: reconfig_o is issued only while busy_i is low;
  // busy_i is then trusted only after the core has had time to raise it.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    rom_sel_d = rom_sel_o;
    active_d  = active_mode_o;
    retry_d   = retry_cnt_o;
    error_d   = error_o;
    failed_d  = failed_mode;
    wfr_d     = 1'b0;
    rcfg_d    = 1'b0;
    rrst_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (force_i || (target != active_mode_o && {1'b0, target} != failed_mode)) begin
          rom_sel_d = target;
          retry_d   = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wfr_d   = 1'b1;
        state_d = ST_GAP;
      end
      ST_GAP: state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (!busy_i) begin
          rcfg_d  = 1'b1;
          timer_d = TW'(BUSY_TIMEOUT);
          state_d = ST_WAIT_CFG;
        end
      end
      ST_WAIT_CFG: begin
        timer_d = timer - TW'(1);
        if (timer <= TW'(1)) begin
          rrst_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (timer <= CFG_CHECK && !busy_i) begin
          timer_d = TW'(LOCK_TIMEOUT);
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        timer_d = timer - TW'(1);
        if (lock_ok) state_d = ST_SUCCESS;
        else if (timer <= TW'(1)) state_d = ST_FAIL;
      end
      ST_SUCCESS: begin
        active_d = rom_sel_o;
        done_d   = 1'b1;
        error_d  = 1'b0;
        failed_d = NONE_MODE;
        state_d  = ST_IDLE;
      end
      ST_FAIL: begin
        if (retry_cnt_o < RETRY_W'(MAX_RETRIES)) begin
          retry_d = retry_cnt_o + RETRY_W'(1);
          state_d = ST_LOAD;
        end else begin
          error_d  = 1'b1;
          failed_d = {1'b0, rom_sel_o};
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Moving the target away from a failed mode re-arms it for a later return.
    if (target != target_q) failed_d = NONE_MODE;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      timer            <= '0;
      target_q         <= RST_MODE;
      rom_sel_o        <= RST_MODE;
      active_mode_o    <= RST_MODE;
      retry_cnt_o      <= '0;
      error_o          <= 1'b0;
      failed_mode      <= NONE_MODE;
      write_from_rom_o <= 1'b0;
      reconfig_o       <= 1'b0;
      reconfig_reset_o <= 1'b0;
      done_o           <= 1'b0;
      seq_busy_o       <= 1'b0;
    end else begin
      state            <= state_d;
      timer            <= timer_d;
      target_q         <= target;
      rom_sel_o        <= rom_sel_d;
      active_mode_o    <= active_d;
      retry_cnt_o      <= retry_d;
      error_o          <= error_d;
      failed_mode      <= failed_d;
      write_from_rom_o <= wfr_d;
      reconfig_o       <= rcfg_d;
      reconfig_reset_o <= rrst_d;
      done_o           <= done_d;
      seq_busy_o       <= (state_d != ST_IDLE);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with a behavioural pll_reconfig busy model
// and a rom_sel scoreboard checked on every write_from_rom_o pulse.
module tb_pll_mode_sequencer;
  import pll_seq_pkg::*;

  localparam int NUM_MODES     = 4;
  localparam int MODE_W        = 2;
  localparam int STABLE_CYCLES = 16;
  localparam int BUSY_TIMEOUT  = 1000;
  localparam int LOCK_TIMEOUT  = 200;
  localparam int MAX_RETRIES   = 3;
  localparam int RETRY_W       = 2;

  logic               clk_i = 1'b0;
  logic               reset_n = 1'b1;
  logic [MODE_W-1:0]  mode_i = '0;
  logic               force_i = 1'b0;
  logic               pll_locked_i = 1'b1;
  logic               busy_i = 1'b0;
  logic               write_from_rom_o, reconfig_o, reconfig_reset_o;
  logic [MODE_W-1:0]  rom_sel_o, active_mode_o;
  logic               seq_busy_o, done_o, error_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  seq_state_t         state_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, n_wfr = 0, n_rcfg = 0, n_rrst = 0, n_done = 0;
  int last_wfr_cyc = 0, last_rcfg_cyc = 0;
  int gap_q[$];
  logic [MODE_W-1:0] exp_q[$];
  logic [MODE_W-1:0] exp_sel;
  bit stuck = 1'b0;
  int busy_left = 0;

  pll_mode_sequencer #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .RESET_MODE(0), .STABLE_CYCLES(STABLE_CYCLES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRIES(MAX_RETRIES),
    .RETRY_W(RETRY_W)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n), .mode_i(mode_i), .force_i(force_i),
    .pll_locked_i(pll_locked_i), .busy_i(busy_i), .write_from_rom_o(write_from_rom_o),
    .reconfig_o(reconfig_o), .reconfig_reset_o(reconfig_reset_o), .rom_sel_o(rom_sel_o),
    .active_mode_o(active_mode_o), .seq_busy_o(seq_busy_o), .done_o(done_o),
    .error_o(error_o), .retry_cnt_o(retry_cnt_o), .state_o(state_o)
  );

  // clock / watchdog
  initial forever #5 clk_i = ~clk_i;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reconfig core model: busy for 5 cycles after reconfig_o, or until reset when stuck
  initial forever begin
    @(negedge clk_i);
    if (reconfig_reset_o) begin
      busy_i = 1'b0; busy_left = 0;
    end else if (reconfig_o) begin
      busy_i = 1'b1; busy_left = stuck ? -1 : 5;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy_i = 1'b0;
    end
  end

  // pulse monitor and rom_sel scoreboard
  initial forever begin
    @(posedge clk_i); #1;
    cyc++;
    if (write_from_rom_o) begin
      n_wfr++; last_wfr_cyc = cyc; vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_rom_sel: unexpected write_from_rom_o, rom_sel_o=%0d", rom_sel_o);
      end else begin
        exp_sel = exp_q.pop_front();
        if (rom_sel_o !== exp_sel) begin
          miscompares++;
          $display("FAIL sb_rom_sel: got %0d expected %0d", rom_sel_o, exp_sel);
        end
      end
    end
    if (reconfig_o) begin n_rcfg++; last_rcfg_cyc = cyc; end
    if (reconfig_reset_o) begin n_rrst++; gap_q.push_back(cyc - last_rcfg_cyc); end
    if (done_o) n_done++;
  end

  task automatic test_reset();
    logic [11:0] obs;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_i);
    obs = {write_from_rom_o, reconfig_o, reconfig_reset_o, rom_sel_o, active_mode_o,
           seq_busy_o, done_o, error_o, retry_cnt_o};
    vectors++;
    if (obs !== 12'h000) begin miscompares++; $display("FAIL reset_outputs: got %h expected 000", obs); end
    vectors++;
    if (state_o !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE); end
    reset_n = 1'b1;
    repeat (30) @(negedge clk_i);
    vectors++;
    if (n_wfr !== 0 || seq_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: wfr=%0d busy=%0d expected 0 0", n_wfr, seq_busy_o);
    end
  endtask

  task automatic test_ntsc_to_pal();
    int found = 0;
    int d0 = n_done;
    exp_q.push_back(2'd1);
    mode_i = 2'd1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (write_from_rom_o) begin found = k; break; end
    end
    vectors++;
    if (found != 20) begin miscompares++; $display("FAIL ntsc_wfr_latency: got %0d expected 20", found); end
    for (int i = 0; i < 100 && n_done == d0; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 1) begin miscompares++; $display("FAIL ntsc_done: got %0d expected %0d", n_done, d0 + 1); end
    vectors++;
    if (last_rcfg_cyc - last_wfr_cyc != 2) begin
      miscompares++; $display("FAIL ntsc_wfr_to_rcfg: got %0d expected 2", last_rcfg_cyc - last_wfr_cyc);
    end
    vectors++;
    if (active_mode_o !== 2'd1) begin miscompares++; $display("FAIL ntsc_active: got %0d expected 1", active_mode_o); end
    vectors++;
    if ({seq_busy_o, error_o, retry_cnt_o} !== 4'b0000) begin
      miscompares++; $display("FAIL ntsc_status: busy/err/retry got %b expected 0000", {seq_busy_o, error_o, retry_cnt_o});
    end
  endtask

  task automatic test_glitch();
    int w0 = n_wfr;
    bit seen = 1'b0;
    mode_i = 2'd2;
    for (int i = 0; i < 65; i++) begin
      if (i == 5) mode_i = 2'd1;
      @(negedge clk_i);
      if (seq_busy_o) seen = 1'b1;
    end
    vectors++;
    if (seen || n_wfr != w0) begin
      miscompares++; $display("FAIL glitch_no_seq: busy_seen=%0d wfr_delta=%0d expected 0 0", seen, n_wfr - w0);
    end
    vectors++;
    if (active_mode_o !== 2'd1) begin miscompares++; $display("FAIL glitch_active: got %0d expected 1", active_mode_o); end
  endtask

  task automatic test_busy_stuck();
    int r0 = n_rrst;
    int w1, g;
    stuck = 1'b1;
    gap_q.delete();
    repeat (4) exp_q.push_back(2'd3);
    mode_i = 2'd3;
    for (int i = 0; i < 6000 && n_rrst < r0 + 4; i++) @(negedge clk_i);
    vectors++;
    if (n_rrst != r0 + 4) begin miscompares++; $display("FAIL stuck_rrst_count: got %0d expected 4", n_rrst - r0); end
    for (int i = 0; i < 4; i++) begin
      g = (gap_q.size() > i) ? gap_q[i] : -1;
      vectors++;
      if (g != BUSY_TIMEOUT) begin miscompares++; $display("FAIL stuck_gap%0d: got %0d expected %0d", i, g, BUSY_TIMEOUT); end
    end
    stuck = 1'b0;
    for (int i = 0; i < 20 && seq_busy_o; i++) @(negedge clk_i);
    vectors++;
    if ({error_o, retry_cnt_o, active_mode_o} !== {1'b1, 2'd3, 2'd1}) begin
      miscompares++; $display("FAIL stuck_status: err=%0d retry=%0d active=%0d expected 1 3 1", error_o, retry_cnt_o, active_mode_o);
    end
    w1 = n_wfr;
    repeat (100) @(negedge clk_i);
    vectors++;
    if (n_wfr != w1 || seq_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL stuck_no_retry: wfr_delta=%0d busy=%0d expected 0 0", n_wfr - w1, seq_busy_o);
    end
  endtask

  task automatic test_lock_recovery();
    int w0, d0, r0;
    pll_locked_i = 1'b0;
    repeat (10) @(negedge clk_i);
    w0 = n_wfr; d0 = n_done; r0 = n_rrst;
    repeat (2) exp_q.push_back(2'd0);
    mode_i = 2'd0;
    for (int i = 0; i < 1000 && n_wfr < w0 + 2; i++) @(negedge clk_i);
    vectors++;
    if (n_wfr != w0 + 2) begin miscompares++; $display("FAIL lock_retry_load: got %0d expected 2", n_wfr - w0); end
    pll_locked_i = 1'b1;
    for (int i = 0; i < 200 && n_done == d0; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 1) begin miscompares++; $display("FAIL lock_done: got %0d expected %0d", n_done, d0 + 1); end
    vectors++;
    if ({retry_cnt_o, error_o, active_mode_o} !== {2'd1, 1'b0, 2'd0}) begin
      miscompares++; $display("FAIL lock_status: retry=%0d err=%0d active=%0d expected 1 0 0", retry_cnt_o, error_o, active_mode_o);
    end
    vectors++;
    if (n_rrst != r0) begin miscompares++; $display("FAIL lock_no_rrst: got %0d expected 0", n_rrst - r0); end
  endtask

  task automatic test_mid_sequence();
    int d0;
    bit reached = 1'b0;
    pll_locked_i = 1'b0;
    repeat (10) @(negedge clk_i);
    d0 = n_done;
    exp_q.push_back(2'd2);
    mode_i = 2'd2;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk_i);
      if (state_o == ST_WAIT_LOCK) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL mid_reach_lock: got %0d expected %0d", state_o, ST_WAIT_LOCK); end
    exp_q.push_back(2'd3);
    mode_i = 2'd3;
    repeat (30) @(negedge clk_i);
    vectors++;
    if (state_o !== ST_WAIT_LOCK || rom_sel_o !== 2'd2) begin
      miscompares++; $display("FAIL mid_hold: state=%0d rom_sel=%0d expected %0d 2", state_o, rom_sel_o, ST_WAIT_LOCK);
    end
    pll_locked_i = 1'b1;
    for (int i = 0; i < 50 && n_done == d0; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 1 || active_mode_o !== 2'd2) begin
      miscompares++; $display("FAIL mid_first: done_delta=%0d active=%0d expected 1 2", n_done - d0, active_mode_o);
    end
    for (int i = 0; i < 200 && n_done == d0 + 1; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 2 || rom_sel_o !== 2'd3 || active_mode_o !== 2'd3) begin
      miscompares++; $display("FAIL mid_second: done_delta=%0d rom_sel=%0d active=%0d expected 2 3 3", n_done - d0, rom_sel_o, active_mode_o);
    end
  endtask

  task automatic test_force();
    int w0 = n_wfr;
    int d0 = n_done;
    exp_q.push_back(2'd3);
    force_i = 1'b1;
    @(negedge clk_i);
    force_i = 1'b0;
    for (int i = 0; i < 100 && n_done == d0; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 1 || n_wfr != w0 + 1) begin
      miscompares++; $display("FAIL force_reapply: done_delta=%0d wfr_delta=%0d expected 1 1", n_done - d0, n_wfr - w0);
    end
    vectors++;
    if (active_mode_o !== 2'd3 || retry_cnt_o !== 2'd0) begin
      miscompares++; $display("FAIL force_status: active=%0d retry=%0d expected 3 0", active_mode_o, retry_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    int r0 = n_rrst;
    int d0;
    bit reached = 1'b0;
    exp_q.push_back(2'd1);
    mode_i = 2'd1;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk_i);
      if (state_o == ST_WAIT_CFG) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL rstmid_reach_cfg: got %0d expected %0d", state_o, ST_WAIT_CFG); end
    repeat (2) @(negedge clk_i);
    reset_n = 1'b0;
    #1;
    obs = {write_from_rom_o, reconfig_o, reconfig_reset_o, rom_sel_o, active_mode_o,
           seq_busy_o, done_o, error_o, retry_cnt_o};
    vectors++;
    if (obs !== 12'h000 || state_o !== ST_IDLE) begin
      miscompares++; $display("FAIL rstmid_outputs: got %h state=%0d expected 000 %0d", obs, state_o, ST_IDLE);
    end
    repeat (3) @(negedge clk_i);
    reset_n = 1'b1;
    exp_q.push_back(2'd1);
    d0 = n_done;
    for (int i = 0; i < 200 && n_done == d0; i++) @(negedge clk_i);
    vectors++;
    if (n_done != d0 + 1 || active_mode_o !== 2'd1) begin
      miscompares++; $display("FAIL rstmid_reapply: done_delta=%0d active=%0d expected 1 1", n_done - d0, active_mode_o);
    end
    vectors++;
    if (n_rrst != r0) begin miscompares++; $display("FAIL rstmid_no_rrst: got %0d expected 0", n_rrst - r0); end
  endtask

  initial begin
    test_reset();
    test_ntsc_to_pal();
    test_glitch();
    test_busy_stuck();
    test_lock_recovery();
    test_mid_sequence();
    test_force();
    test_reset_mid();
    repeat (5) @(negedge clk_i);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_mode_sequencer.md
# pll_mode_sequencer

Runtime PLL reconfiguration sequencer that switches the system PLL between `NUM_MODES` precomputed configurations, such as PAL, NTSC and 50/60 Hz variants. It sits between the video-standard select logic and the vendor `pll_reconfig` megafunction, which is fed by one scan-chain ROM per mode. The sequencer adds four things over a simple two-mode sequencer:

- input debouncing across clock domains;
- a stable ROM select held for the whole transfer;
- a wait for PLL lock after reconfiguration;
- bounded retry with error reporting.

## Interface
Parameters:
- `NUM_MODES`, 2, number of PLL configurations (ROM images); ≥2.
- `MODE_W`, `$clog2(NUM_MODES)`, width of mode fields.
- `RESET_MODE`, 0, configuration compiled into the PLL; value of `active_mode_o` after reset.
- `STABLE_CYCLES`, 16, cycles the synchronised `mode_i` must hold before it is accepted.
- `BUSY_TIMEOUT`, 1000, cycles allowed for reconfig core busy after the `reconfig_o` pulse.
- `LOCK_TIMEOUT`, 65535, cycles allowed for PLL lock after reconfiguration.
- `MAX_RETRIES`, 3, extra attempts after the first failure.

Ports (each line: name, direction, width, meaning). One clock; reset is asynchronous and active-low.
- `clk_i` in 1: reference clock, the PLL input clock.
- `reset_n` in 1: asynchronous active-low reset.
- `mode_i` in `MODE_W`: requested mode; asynchronous to `clk_i`; values ≥ `NUM_MODES` are ignored.
- `force_i` in 1: single-cycle request to reapply the current target.
- `pll_locked_i` in 1: PLL locked; asynchronous.
- `busy_i` in 1: `pll_reconfig` busy.
- `write_from_rom_o` out 1: single-cycle pulse that loads the scan chain from ROM.
- `reconfig_o` out 1: single-cycle pulse that starts reconfiguration.
- `reconfig_reset_o` out 1: single-cycle pulse that resets a stuck reconfig core.
- `rom_sel_o` out `MODE_W`: ROM image select feeding the `rom_data_in` mux.
- `active_mode_o` out `MODE_W`: last successfully applied mode.
- `seq_busy_o` out 1: sequencer not in IDLE.
- `done_o` out 1: single-cycle pulse on successful completion.
- `error_o` out 1: sticky; last attempt exhausted its retries.
- `retry_cnt_o` out `$clog2(MAX_RETRIES+1)`: retries used by the current or last attempt.

## Operation
Input conditioning:
- `mode_i` and `pll_locked_i` each pass through a 2-flop synchroniser.
- A stability counter restarts on any change of the synchronised mode. When it reaches `STABLE_CYCLES`, `target` is updated, provided the value is < `NUM_MODES`.

States:
- **IDLE**
  - Start a sequence when `target != active_mode_o` and `target != failed_mode`, or when `force_i` is asserted.
  - On start: latch `rom_sel_o <= target`, clear `retry_cnt`, go to LOAD.
- **LOAD**: pulse `write_from_rom_o`, go to GAP.
- **GAP**: one cycle, go to WAIT_IDLE.
- **WAIT_IDLE**: when `busy_i` is low, pulse `reconfig_o`, load the timer with `BUSY_TIMEOUT`, go to WAIT_CFG.
- **WAIT_CFG**
  - The timer decrements each cycle.
  - `busy_i` is ignored in the first 2 cycles.
  - After that, `busy_i` low loads the timer with `LOCK_TIMEOUT` and goes to WAIT_LOCK.
  - Timer reaching 1: pulse `reconfig_reset_o`, go to FAIL.
- **WAIT_LOCK**
  - Synchronised lock high for 4 consecutive cycles → SUCCESS.
  - Timer reaching 1 → FAIL.
- **SUCCESS**
  - `active_mode_o <= rom_sel_o`, pulse `done_o`.
  - Clear `error_o` and `failed_mode` (to `NUM_MODES`, meaning none), go to IDLE.
- **FAIL**
  - If `retry_cnt < MAX_RETRIES`: increment and go to LOAD.
  - Otherwise: set `error_o`, `failed_mode <= rom_sel_o`, go to IDLE. `active_mode_o` is unchanged.

Rules:
- `rom_sel_o` changes only on the IDLE→LOAD transition.
- Target changes during a sequence are not acted on until IDLE. The new target is then compared and a fresh sequence starts.
- A failed mode is not retried automatically. It is retried only on `force_i` or after the target changes away and back.
- `force_i` outside IDLE is dropped.

## Timing
Reset values:
- All pulse outputs 0, `seq_busy_o` 0, `error_o` 0, `retry_cnt_o` 0.
- `rom_sel_o` and `active_mode_o` = `RESET_MODE`; `target` = `RESET_MODE`; `failed_mode` = none.

Latencies:
- `mode_i` change to `write_from_rom_o`: 2 (sync) + `STABLE_CYCLES` + 1 (IDLE decision) + 1 cycles.
- `write_from_rom_o` to `reconfig_o`: ≥2 cycles.
- `done_o` fires 1 cycle after the 4th consecutive locked sample.

Pulses and status:
- All pulses are exactly one cycle and are registered outputs.
- `seq_busy_o` is high from the cycle after the IDLE decision through SUCCESS/FAIL exit.

Reset behaviour:
- Reset mid-sequence aborts immediately; no `reconfig_reset_o` pulse is generated.
- The PLL may hold a partial config. After reset the sequencer re-applies if `target` ≠ `RESET_MODE`.

## Structure
- Package `pll_seq_pkg`: a state enum and the `NONE_MODE` encoding (`NUM_MODES`, carried in `MODE_W+1` bits for `failed_mode`).
- Sub-module `mode_debounce`: synchroniser plus stability counter, reused for `pll_locked_i` with STABLE=4.
- The ROM instances and data mux live in the parent clocks block; they are not part of this block.

## Test plan
- **NTSC→PAL:** `NUM_MODES`=2, `STABLE_CYCLES`=16, reset, then `mode_i` 0→1. Required: `write_from_rom_o` at cycle 20, `reconfig_o` ≥2 cycles later, `done_o`, `active_mode_o`=1.
- **Glitch rejection:** `mode_i` toggles 1 for 5 cycles then returns to 0. Required: no sequence, `seq_busy_o` stays 0.
- **Busy stuck:** `busy_i` held high after `reconfig_o`, `BUSY_TIMEOUT`=1000, `MAX_RETRIES`=3. Required: 4 `reconfig_reset_o` pulses 1000 cycles apart, then `error_o`=1, `retry_cnt_o`=3, `active_mode_o` unchanged, no re-attempt until `force_i`.
- **Mid-sequence change:** `NUM_MODES`=4; change mode 0→2 during WAIT_LOCK, then 2→3. Required: sequence for 2 completes with `active_mode_o`=2, then a second sequence runs with `rom_sel_o`=3.
- **Lock timeout recovery:** lock withheld on the first attempt and restored on the second. Required: `done_o` with `retry_cnt_o`=1 and `error_o` cleared.
- **Reset mid-sequence:** assert `reset_n` in WAIT_CFG. Required: all outputs at reset values the same cycle; after release, a sequence to the held `mode_i` starts.
